// File: rtl/synaptic_current_gen.sv
// Spike-to-current front end for the LIF neuron: weighted spike sum integrated
// into an 8-bit current register with periodic exponential decay and saturation.
module synaptic_current_gen #(
  parameter int N_INPUTS     = 4,
  parameter int DECAY_SHIFT  = 2,
  parameter int DECAY_PERIOD = 4,
  localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] spike_in,
  input  logic                start,
  input  logic                stop,
  input  logic                cfg_valid,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [7:0]          cfg_weight,
  output logic                cfg_ready,
  output logic [7:0]          synaptic_current,
  output logic                saturated,
  output logic                busy
);

  localparam int SUM_W = 8 + $clog2(N_INPUTS);
  localparam int TOT_W = SUM_W + 1;
  localparam int CW    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_PERIOD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [7:0]       weight [N_INPUTS];
  logic [CW-1:0]    cnt;
  logic             tick;
  logic [SUM_W-1:0] sum;
  logic [7:0]       decayed;
  logic [TOT_W-1:0] total;
  logic             addr_ok;

  // The 1-LSB floor keeps small currents shrinking so DRAIN always reaches 0.
  function automatic logic [7:0] decay_step(input logic [7:0] i, input logic tick_en);
    logic [7:0] step;
    step = i >> DECAY_SHIFT;
    if (step == 8'd0) step = 8'd1;
    if (tick_en && (i != 8'd0)) return i - step;
    return i;
  endfunction

  function automatic logic [7:0] sat8(input logic [TOT_W-1:0] v);
    return (v > TOT_W'(255)) ? 8'd255 : v[7:0];
  endfunction

  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign tick      = (cnt == CNT_LAST);
  assign addr_ok   = (int'(cfg_addr) < N_INPUTS);

  // Spikes only contribute while running; DRAIN forces the sum to zero.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (spike_in[i] && (state == S_RUN)) sum = sum + SUM_W'(weight[i]);
    end
  end

  assign decayed = decay_step(synaptic_current, tick);
  assign total   = TOT_W'(decayed) + TOT_W'(sum);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (stop) state_nxt = S_DRAIN;
      S_DRAIN: if (synaptic_current == 8'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      synaptic_current <= 8'd0;
      saturated        <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_RUN, S_DRAIN: begin
          cnt              <= tick ? '0 : cnt + 1'b1;
          synaptic_current <= sat8(total);
          saturated        <= (total > TOT_W'(255));
        end
        default: begin
          cnt              <= '0;
          synaptic_current <= 8'd0;
          saturated        <= 1'b0;
        end
      endcase
    end
  end

  // Weights are writable only in IDLE; out-of-range addresses are accepted and dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_INPUTS; i++) weight[i] <= 8'd0;
    end else if (cfg_valid && cfg_ready && addr_ok) begin
      weight[cfg_addr] <= cfg_weight;
    end
  end

endmodule

// File: tb/tb_synaptic_current_gen.sv
// Directed bench for synaptic_current_gen with default parameters (4 inputs,
// shift 2, decay period 4); expected values are worked out by hand per step.
module tb_synaptic_current_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] spike_in;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_weight;
  logic       cfg_ready;
  logic [7:0] synaptic_current;
  logic       saturated;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  synaptic_current_gen #(
    .N_INPUTS(4), .DECAY_SHIFT(2), .DECAY_PERIOD(4)
  ) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight),
    .cfg_ready(cfg_ready), .synaptic_current(synaptic_current),
    .saturated(saturated), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] w);
    cfg_valid = 1'b1; cfg_addr = a; cfg_weight = w;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; spike_in = '0; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_weight = '0;
    repeat (2) cyc();
    rst = 1'b0;

    // Scramble state before the reset under test
    cfg_write(2'd0, 8'd200);
    do_start();
    for (int i = 0; i < 3; i++) begin
      spike_in = 4'($urandom_range(0, 15));
      cyc();
    end
    spike_in = '0;
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    check("rst_current", 16'(synaptic_current), 16'd0);
    check("rst_saturated", 16'(saturated), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_cfg_ready", 16'(cfg_ready), 16'd1);

    do_start();
    check("start_busy", 16'(busy), 16'd1);
    check("start_cfg_ready", 16'(cfg_ready), 16'd0);
    repeat (5) cyc();
    check("start_nospike_current", 16'(synaptic_current), 16'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("drain0_busy", 16'(busy), 16'd1);
    cyc();
    check("drain0_idle", 16'(busy), 16'd0);

    // Integration: weights 10,20,30,40, spikes on inputs 0 and 2
    cfg_write(2'd0, 8'd10);
    cfg_write(2'd1, 8'd20);
    cfg_write(2'd2, 8'd30);
    cfg_write(2'd3, 8'd40);
    do_start();
    spike_in = 4'b0101;
    cyc();
    spike_in = '0;
    check("integ_current", 16'(synaptic_current), 16'd40);
    check("integ_saturated", 16'(saturated), 16'd0);
    cyc();
    check("hold40_a", 16'(synaptic_current), 16'd40);
    cyc();
    check("hold40_b", 16'(synaptic_current), 16'd40);
    cyc();
    check("decay_30", 16'(synaptic_current), 16'd30);
    repeat (3) cyc();
    check("hold30", 16'(synaptic_current), 16'd30);
    cyc();
    check("decay_23", 16'(synaptic_current), 16'd23);
    repeat (3) cyc();
    check("hold23", 16'(synaptic_current), 16'd23);
    cyc();
    check("decay_18", 16'(synaptic_current), 16'd18);
    repeat (3) cyc();
    check("hold18", 16'(synaptic_current), 16'd18);
    cyc();
    check("decay_14", 16'(synaptic_current), 16'd14);

    // Saturation: 4 x 100 = 400 clips to 255 on a non-tick cycle
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) cfg_write(2'(a), 8'd100);
    do_start();
    spike_in = 4'b1111;
    cyc();
    spike_in = '0;
    check("sat_current", 16'(synaptic_current), 16'd255);
    check("sat_flag_set", 16'(saturated), 16'd1);
    cyc();
    check("sat_flag_clear", 16'(saturated), 16'd0);
    check("sat_hold", 16'(synaptic_current), 16'd255);

    // Drain from 3 with floor decay 3 -> 2 -> 1 -> 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cfg_write(2'd0, 8'd3);
    do_start();
    spike_in = 4'b0001;
    cyc();
    spike_in = '0;
    check("drain_pre", 16'(synaptic_current), 16'd3);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("drain_entry_busy", 16'(busy), 16'd1);
    check("drain_entry_current", 16'(synaptic_current), 16'd3);
    spike_in = 4'b1111;
    cyc();
    check("drain_spike_ignored", 16'(synaptic_current), 16'd3);
    cyc();
    check("drain_2", 16'(synaptic_current), 16'd2);
    repeat (3) cyc();
    check("drain_hold2", 16'(synaptic_current), 16'd2);
    cyc();
    check("drain_1", 16'(synaptic_current), 16'd1);
    repeat (3) cyc();
    check("drain_hold1", 16'(synaptic_current), 16'd1);
    cyc();
    check("drain_0", 16'(synaptic_current), 16'd0);
    check("drain_0_busy", 16'(busy), 16'd1);
    cyc();
    check("drain_idle_busy", 16'(busy), 16'd0);
    check("drain_idle_cfg_ready", 16'(cfg_ready), 16'd1);
    spike_in = '0;

    // Config lockout during RUN, then reset mid-run clears weights
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cfg_write(2'd0, 8'd10);
    cfg_write(2'd1, 8'd20);
    cfg_write(2'd2, 8'd30);
    cfg_write(2'd3, 8'd40);
    do_start();
    cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_weight = 8'd99;
    #1;
    check("lock_cfg_ready", 16'(cfg_ready), 16'd0);
    cyc();
    cfg_valid = 1'b0;
    spike_in = 4'b0001;
    cyc();
    spike_in = '0;
    check("lock_weight_kept", 16'(synaptic_current), 16'd10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrun_rst_busy", 16'(busy), 16'd0);
    check("midrun_rst_current", 16'(synaptic_current), 16'd0);
    do_start();
    spike_in = 4'b1111;
    cyc();
    spike_in = '0;
    check("weights_cleared", 16'(synaptic_current), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/synaptic_current_gen.md
# synaptic_current_gen

Upstream stage of the current-based LIF neuron. It converts a bundle of binary input spikes into the 8-bit `synaptic_current` the neuron integrates. Each input has a programmable 8-bit weight. Weighted spikes are summed into a registered current that decays exponentially at a fixed tick rate and saturates at 255. A small FSM handles weight loading, run, and drain to zero.

## Interface

Parameters:
- `N_INPUTS`, default 4: number of spike inputs (2..16).
- `DECAY_SHIFT`, default 2: decay step is `I >> DECAY_SHIFT`.
- `DECAY_PERIOD`, default 4: cycles between decay ticks (≥1).

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `spike_in`  in  N_INPUTS: presynaptic spikes, sampled every cycle.
- `start`  in  1: pulse, IDLE→RUN.
- `stop`  in  1: pulse, RUN→DRAIN.
- `cfg_valid`  in  1: weight write request.
- `cfg_addr`  in  clog2(N_INPUTS) (min 1): weight index.
- `cfg_weight`  in  8: weight value, unsigned.
- `cfg_ready`  out  1: weight write accepted when `cfg_valid && cfg_ready`.
- `synaptic_current`  out  8: registered current, feeds the neuron.
- `saturated`  out  1: registered; high the cycle after clipping occurred.
- `busy`  out  1: high when state ≠ IDLE.

## Operation

- **Reset** (`rst`=1 at edge): state IDLE, all weights 0, `synaptic_current`=0, `saturated`=0, decay counter 0. Combinational outputs then read `cfg_ready`=1 and `busy`=0. Reset mid-RUN or mid-DRAIN behaves the same and also clears the weights.
- **States:**
  - **IDLE**
    - `cfg_ready`=1; a handshake writes `weight[cfg_addr] <= cfg_weight`.
    - `cfg_addr` ≥ N_INPUTS: write is accepted and dropped.
    - Current holds 0. Spikes are ignored.
    - `start`: go to RUN, clear decay counter. A write in the same cycle still completes.
  - **RUN**
    - `cfg_ready`=0. Integrate and decay as below.
    - `stop`: go to DRAIN. `stop` wins over `start`; `start` alone is ignored.
  - **DRAIN**
    - `cfg_ready`=0. Spikes are ignored (sum forced to 0). Decay continues.
    - When the registered current is 0, go to IDLE on the next edge.
    - `start` and `stop` are ignored.
- **Decay counter:** counts 0..DECAY_PERIOD-1 and wraps in RUN and DRAIN. `tick` = (counter == DECAY_PERIOD-1).
- **Per-cycle update** in RUN/DRAIN, with I = current register:
  - `sum` = Σ weight[i] over i with spike_in[i]=1, width 8+clog2(N_INPUTS), no overflow.
  - `decayed` = I − max(I >> DECAY_SHIFT, 1) if tick and I>0; else I. The 1-LSB floor guarantees DRAIN terminates.
  - `total` = decayed + sum.
  - `synaptic_current` <= min(total, 255).
  - `saturated` <= (total > 255).
- Decay and integration in the same cycle: decay applies first, then spikes are added.
- In IDLE, `saturated` <= 0.

## Timing

- Spike sampled at edge t; its weight appears on `synaptic_current` after edge t (1-cycle latency).
- `start` sampled at edge t: the first RUN cycle is t+1 with counter=0. The first tick falls on the RUN cycle with counter = DECAY_PERIOD-1, so its result is visible after DECAY_PERIOD edges.
- `stop` at edge t: DRAIN from t+1.
- DRAIN→IDLE: the edge after the registered current reads 0. `busy` falls on that same edge.
- Duration of DRAIN with current 0 at entry: 1 cycle.
- `cfg_ready` is a combinational decode of state. It has no dependence on `cfg_valid`.

## Test plan

1. **Reset:** assert `rst` 2 cycles from random state → `synaptic_current`=0, `saturated`=0, `busy`=0, `cfg_ready`=1. Then `start` with no spikes → current stays 0.
2. **Integration:** write weights 10,20,30,40 to addr 0..3, `start`. On the first RUN cycle drive `spike_in`=4'b0101 → current 40 after that edge, `saturated`=0.
3. **Decay:** continue from 40 with no spikes → current becomes 30 at the first tick. Subsequent ticks, every 4 cycles, give 23, 18, 14. Values hold constant between ticks.
4. **Saturation:** weights all 100, `spike_in`=4'b1111 for one non-tick cycle from current 0 → current 255, `saturated`=1 for exactly one cycle. Next cycle with no spikes: `saturated`=0.
5. **Drain:** `stop` with current 3 → DRAIN. Successive ticks give 2, 1, 0, then IDLE and `busy`=0 one cycle later. Spikes during DRAIN do not change the current.
6. **Config lockout and reset mid-run:** `cfg_valid` with weight 99 during RUN → `cfg_ready`=0, weight unchanged (verified by a spike). Assert `rst` mid-RUN → all weights read back 0 (spikes produce current 0 after the next `start`).
